// File: rtl/sqrt_pkg.sv
// Shared types and constants for the integer square-root sequencer.
// The default operand width and the latency helper are also used by benches.
package sqrt_pkg;

  localparam int SQRT_WIDTH = 16;
  localparam int ROOT_W     = SQRT_WIDTH / 2;
  localparam int ITER_W     = $clog2(ROOT_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SHIFT  = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } sqrt_state_t;

  // Cycles from the accepting edge to the DONE cycle.
  function automatic int sqrt_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/sqrt_ctrl_if.sv
// Start/busy/done handshake, results and root-register strobes of sqrt_ctrl.
interface sqrt_ctrl_if
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
);
  localparam int RW = WIDTH / 2;

  logic             start;
  logic             clear;
  logic [WIDTH-1:0] in_A;
  logic             busy;
  logic             done;
  logic [RW-1:0]    root;
  logic [RW:0]      rem;
  logic             ctl_load;
  logic             ctl_shift;
  logic             ctl_load_r0;
  logic             ctl_bit;

  modport master (
    output start, clear, in_A,
    input  busy, done, root, rem, ctl_load, ctl_shift, ctl_load_r0, ctl_bit
  );

  modport slave (
    input  start, clear, in_A,
    output busy, done, root, rem, ctl_load, ctl_shift, ctl_load_r0, ctl_bit
  );

endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root step: compare the partial remainder with the
// trial value {root, 01} and subtract it when it fits.
module sqrt_step #(
  parameter int RW = 8
) (
  input  logic [RW+1:0] prem_s,
  input  logic [RW-1:0] root_s,
  output logic [RW+1:0] prem_nxt_s,
  output logic [RW-1:0] root_nxt_s,
  output logic          take_s
);

  logic [RW+1:0] trial_s;

  // Trial compare and conditional subtract.
  always_comb begin
    trial_s = {root_s, 2'b01};
    take_s  = (prem_s >= trial_s);
    if (take_s) begin
      prem_nxt_s = prem_s - trial_s;
      root_nxt_s = {root_s[RW-2:0], 1'b1};
    end else begin
      prem_nxt_s = prem_s;
      root_nxt_s = {root_s[RW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_ctrl.sv
// Integer square-root sequencer: one root bit per SHIFT/DECIDE pair, plus
// registered load/shift/insert strobes for the external root register.
module sqrt_ctrl
  import sqrt_pkg::*;
#(
  parameter int WIDTH = SQRT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  sqrt_ctrl_if.slave  bus
);

  localparam int RW = WIDTH / 2;
  localparam int IW = (RW > 1) ? $clog2(RW) : 1;
  localparam int PW = RW + 2;

  sqrt_state_t      state_r;
  logic [WIDTH-1:0] opnd_r;
  logic [PW-1:0]    prem_r;
  logic [PW-1:0]    prem_shift_s;
  logic [PW-1:0]    step_in_s;
  logic [PW-1:0]    step_prem_s;
  logic [RW-1:0]    root_q_r;
  logic [RW-1:0]    step_root_s;
  logic             step_take_s;
  logic [IW-1:0]    iter_r;
  logic             last_s;
  logic             busy_r;
  logic             done_r;
  logic [RW-1:0]    root_r;
  logic [RW:0]      rem_r;
  logic             ctl_load_r;
  logic             ctl_shift_r;
  logic             ctl_load_r0_r;
  logic             ctl_bit_r;

  assign prem_shift_s = {prem_r[RW-1:0], opnd_r[WIDTH-1 -: 2]};
  assign last_s       = (iter_r == IW'(RW - 1));

  // In SHIFT the step looks ahead at the shifted remainder so the inserted
  // bit can be registered together with the DECIDE strobe.
  always_comb begin
    step_in_s = prem_r;
    if (state_r == S_SHIFT) begin
      step_in_s = prem_shift_s;
    end else begin
      step_in_s = prem_r;
    end
  end

  sqrt_step #(.RW(RW)) u_step (
    .prem_s     (step_in_s),
    .root_s     (root_q_r),
    .prem_nxt_s (step_prem_s),
    .root_nxt_s (step_root_s),
    .take_s     (step_take_s)
  );

  // Sequencer state, datapath registers and next-state-decoded outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      opnd_r        <= '0;
      prem_r        <= '0;
      root_q_r      <= '0;
      iter_r        <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      root_r        <= '0;
      rem_r         <= '0;
      ctl_load_r    <= 1'b0;
      ctl_shift_r   <= 1'b0;
      ctl_load_r0_r <= 1'b0;
      ctl_bit_r     <= 1'b0;
    end else if (bus.clear) begin
      state_r       <= S_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      root_r        <= '0;
      rem_r         <= '0;
      ctl_load_r    <= 1'b0;
      ctl_shift_r   <= 1'b0;
      ctl_load_r0_r <= 1'b0;
      ctl_bit_r     <= 1'b0;
    end else begin
      done_r        <= 1'b0;
      ctl_load_r    <= 1'b0;
      ctl_shift_r   <= 1'b0;
      ctl_load_r0_r <= 1'b0;
      ctl_bit_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            state_r    <= S_INIT;
            opnd_r     <= bus.in_A;
            prem_r     <= '0;
            root_q_r   <= '0;
            iter_r     <= '0;
            busy_r     <= 1'b1;
            ctl_load_r <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        S_INIT: begin
          state_r     <= S_SHIFT;
          busy_r      <= 1'b1;
          ctl_shift_r <= 1'b1;
        end
        S_SHIFT: begin
          state_r       <= S_DECIDE;
          busy_r        <= 1'b1;
          prem_r        <= prem_shift_s;
          opnd_r        <= {opnd_r[WIDTH-3:0], 2'b00};
          ctl_load_r0_r <= 1'b1;
          ctl_bit_r     <= step_take_s;
        end
        S_DECIDE: begin
          busy_r   <= 1'b1;
          prem_r   <= step_prem_s;
          root_q_r <= step_root_s;
          iter_r   <= iter_r + IW'(1);
          if (last_s) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
            root_r  <= step_root_s;
            rem_r   <= step_prem_s[RW:0];
          end else begin
            state_r     <= S_SHIFT;
            ctl_shift_r <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.root        = root_r;
  assign bus.rem         = rem_r;
  assign bus.ctl_load    = ctl_load_r;
  assign bus.ctl_shift   = ctl_shift_r;
  assign bus.ctl_load_r0 = ctl_load_r0_r;
  assign bus.ctl_bit     = ctl_bit_r;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Scoreboard bench for sqrt_ctrl: expected results come from a plain
// arithmetic isqrt model; a monitor checks results, latency and strobes.
module tb_sqrt_ctrl;

  localparam int W  = 16;
  localparam int RW = W / 2;

  typedef struct {
    int unsigned root;
    int unsigned rem;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned done_cnt = 0;
  int unsigned last_acc = 0;
  exp_t        q[$];

  int unsigned n_load = 0;
  int unsigned n_shift = 0;
  int unsigned n_r0 = 0;
  int unsigned n_excl = 0;
  logic [RW-1:0] shadow = '0;

  sqrt_ctrl_if #(.WIDTH(W)) bus ();

  sqrt_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: largest r with r*r <= a, remainder a - r*r.
  function automatic exp_t model(input int unsigned a, input int unsigned acc);
    exp_t e;
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    e.root = r;
    e.rem  = a - r * r;
    e.acc  = acc;
    return e;
  endfunction

  task automatic flush();
    q.delete();
    n_load = 0; n_shift = 0; n_r0 = 0; n_excl = 0; shadow = '0;
  endtask

  task automatic run_op(input int unsigned a);
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("idle_timeout", 1, 0);
    bus.start = 1'b1;
    bus.in_A  = a[W-1:0];
    last_acc  = cyc + 1;
    q.push_back(model(a, last_acc));
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_A  = W'($urandom);
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q.size() != 0 || bus.busy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("drain_timeout", 1, 0);
  endtask

  // Monitor: strobe accounting on the falling edge, result check on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((32'(bus.ctl_load) + 32'(bus.ctl_shift) + 32'(bus.ctl_load_r0)) > 1) n_excl++;
      if (bus.ctl_load) begin
        shadow = '0;
        n_load++;
      end
      if (bus.ctl_shift) begin
        shadow = {shadow[RW-2:0], 1'b0};
        n_shift++;
      end
      if (bus.ctl_load_r0) begin
        shadow[0] = bus.ctl_bit;
        n_r0++;
      end
      if (bus.done) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("root", 32'(bus.root), e.root);
          check("rem", 32'(bus.rem), e.rem);
          check("latency", cyc - e.acc + 1, W + 2);
          check("n_load", n_load, 1);
          check("n_shift", n_shift, RW);
          check("n_load_r0", n_r0, RW);
          check("strobe_overlap", n_excl, 0);
          check("shadow_reg", 32'(shadow), e.root);
        end
        n_load = 0; n_shift = 0; n_r0 = 0; n_excl = 0;
      end
    end
  end

  initial begin
    int unsigned d0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.in_A  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    check("rst_strobes", {bus.ctl_load, bus.ctl_shift, bus.ctl_load_r0, bus.ctl_bit}, 0);
    check("rst_root_rem", {bus.root, bus.rem}, 0);
    reset = 1'b1;

    // Directed operands, then random ones issued back to back or with gaps.
    run_op(144);
    run_op(200);
    run_op(0);
    run_op(65535);
    run_op(1);
    run_op(65024);
    for (int i = 0; i < 20; i++) begin
      run_op($urandom_range(0, 65535));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    // Starts during the computation and in the DONE cycle are ignored.
    run_op(144);
    wait_cyc(last_acc + 4);
    bus.start = 1'b1; bus.in_A = 16'd81;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(last_acc + 17);
    bus.start = 1'b1; bus.in_A = 16'd81;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_done", 32'(bus.busy), 0);
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(bus.busy), 0);
    wait_drain();

    // Asynchronous reset in the middle of a computation.
    run_op(50000);
    wait_cyc(last_acc + 8);
    reset = 1'b0;
    #1;
    check("areset_busy_done", {bus.busy, bus.done}, 0);
    check("areset_strobes", {bus.ctl_load, bus.ctl_shift, bus.ctl_load_r0, bus.ctl_bit}, 0);
    check("areset_root_rem", {bus.root, bus.rem}, 0);
    @(negedge clk);
    @(negedge clk);
    flush();
    reset = 1'b1;
    run_op(49);
    wait_drain();

    // Synchronous clear in cycle 6 aborts without a done pulse.
    run_op(30000);
    wait_cyc(last_acc + 5);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    flush();
    check("clear_busy", 32'(bus.busy), 0);
    check("clear_root_rem", {bus.root, bus.rem}, 0);
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    check("clear_no_done", done_cnt, d0);

    run_op(65535);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_ctrl.md
# sqrt_ctrl

Sequencer for the calculator's integer square-root unit. It accepts an unsigned operand on a start/busy/done handshake and runs the digit-by-digit restoring square-root algorithm, one result bit per two cycles. It holds its own partial-remainder and root registers, so its results stand alone. It also drives the load/shift/bit-insert strobes of the external root shift register that feeds the display path.

## Interface
- `WIDTH`, default 16: operand width; must be even; `ROOT_W = WIDTH/2`; iterations = `ROOT_W`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `clear` input 1: synchronous abort; returns to IDLE and zeroes results.
- `in_A` input WIDTH: radicand; captured on the accepting edge.
- `busy` output 1: high from INIT through DONE.
- `done` output 1: one-cycle pulse; results valid from this cycle on.
- `root` output ROOT_W: floor(sqrt(in_A)).
- `rem` output ROOT_W+1: `in_A - root*root`, with a maximum of `2*root`.
- `ctl_load` output 1: load strobe for the external root register, which is loaded with 0.
- `ctl_shift` output 1: shift-left strobe for the external root register.
- `ctl_load_r0` output 1: LSB-insert strobe for the external root register.
- `ctl_bit` output 1: bit to insert; meaningful only while `ctl_load_r0` is high.

## Operation
- States: IDLE, INIT, SHIFT, DECIDE, DONE.
- IDLE → INIT when `start` is 1. On that edge:
  - capture `in_A` into operand register `opnd`;
  - clear the internal partial remainder `prem` (ROOT_W+2 bits), `root_q` and iteration counter `iter`.
- INIT:
  - `ctl_load` = 1 for one cycle;
  - → SHIFT.
- SHIFT:
  - `prem <= {prem, opnd[WIDTH-1:WIDTH-2]}`, truncated to the `prem` width;
  - `opnd <<= 2`;
  - `ctl_shift` = 1;
  - → DECIDE.
- DECIDE:
  - `trial = {root_q, 2'b01}`, zero-extended to the `prem` width;
  - if `prem >= trial`: `prem -= trial`, `root_q <= {root_q, 1}`, `ctl_bit` = 1;
  - otherwise: `root_q <= {root_q, 0}`, `ctl_bit` = 0;
  - `ctl_load_r0` = 1;
  - `iter++`;
  - → DONE if `iter == ROOT_W-1` before the increment, else → SHIFT.
- DONE:
  - `done` = 1;
  - `root`/`rem` registers take `root_q`/`prem` on the edge entering DONE;
  - → IDLE unconditionally.
- All `ctl_*` outputs and `done` are registered, decoded from the next state. They are mutually exclusive: at most one strobe is high in any cycle.
- `start` outside IDLE is ignored (no queueing), including in the DONE cycle.
- `clear` has priority over `start` and over all state transitions. It causes:
  - → IDLE;
  - `root` = `rem` = 0;
  - all strobes 0.
- `root`/`rem` hold their value from DONE until the next accepted start. They are not cleared on start.

## Timing
- Accepting edge E0 (IDLE with `start` = 1):
  - `busy` = 1 from cycle 1;
  - INIT in cycle 1;
  - SHIFT/DECIDE pairs in cycles 2–(2·ROOT_W+1);
  - DONE in cycle 2·ROOT_W+2, which is cycle 18 for WIDTH = 16.
- `busy` falls in the cycle after DONE. The earliest next accept is at the edge ending DONE+1, so the throughput is 1 result per WIDTH+3 cycles.
- Strobes are rising-edge registered and stable for the full cycle. The external root register samples them on the falling edge, which gives a half-cycle setup margin. Strobes must be glitch-free.
- `reset` low (asynchronous, any time, including mid-computation):
  - state = IDLE;
  - `busy`, `done`, all `ctl_*`, `root`, `rem`, `prem`, `root_q`, `iter`, `opnd` = 0.
- Reset release is synchronized by the clock. The first `start` is accepted at the first rising edge with `reset` = 1.
- Width rules:
  - `prem` is ROOT_W+2 bits so that the compare never overflows;
  - the maximum final `prem` is `2·root` ≤ 2^(ROOT_W+1)−2, which fits the `rem` output width;
  - `rem` is the low ROOT_W+1 bits of `prem`.

## Structure
- Package `sqrt_pkg`:
  - state enum `sqrt_state_t`;
  - localparams `ROOT_W`, `ITER_W = $clog2(ROOT_W)`;
  - function computing the latency `WIDTH+2` for benches.
- Sub-module `sqrt_step`: purely combinational. It takes `prem`, `root_q` and returns next `prem`, next root bit and the decision. It is instantiated once in the DECIDE path.
- The FSM, counter and operand/result registers live in `sqrt_ctrl`.

## Test plan
- `in_A` = 144 → `done` in cycle 18, `root` = 12, `rem` = 0. `ctl_bit` sequence over the 8 DECIDE cycles is 0,0,0,0,1,1,0,0.
- `in_A` = 200 → `root` = 14, `rem` = 4. `in_A` = 0 → `root` = 0, `rem` = 0.
- `in_A` = 65535 → `root` = 255, `rem` = 510 (checks the widest remainder and compare width).
- Strobe accounting per operation:
  - exactly 1 `ctl_load`, 8 `ctl_shift`, 8 `ctl_load_r0`;
  - never two strobes high in the same cycle;
  - a shadow shift register driven by the strobes ends equal to `root`.
- Pulse `start` with `in_A` = 81 while busy in cycle 5 and again in the DONE cycle → both ignored; result is from the original operand.
- Drive `reset` low in cycle 9 of a computation → all outputs 0 immediately (asynchronous). A new start after release with `in_A` = 49 gives `root` = 7, `rem` = 0 in cycle 18. `clear` in cycle 6 → IDLE next cycle, `root` = `rem` = 0, `done` never pulses.
